hex_scroll_display: RTL and testbench



---
 rtl/hex_scroll_pkg.sv | 38 +++
 rtl/seg7_char_decode.sv | 23 ++
 rtl/hex_scroll_display.sv | 136 +++++++++++++
 tb/tb_hex_scroll_display.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the scrolling HEX display: character codes, segment
// patterns, the run/pause state type and the power-on word contents.
package hex_scroll_pkg;

    localparam logic [2:0] CH_D     = 3'd0;
    localparam logic [2:0] CH_E     = 3'd1;
    localparam logic [2:0] CH_1     = 3'd2;
    localparam logic [2:0] CH_BLANK = 3'd3;
    localparam logic [2:0] CH_H     = 3'd4;
    localparam logic [2:0] CH_L     = 3'd5;
    localparam logic [2:0] CH_O     = 3'd6;
    localparam logic [2:0] CH_P     = 3'd7;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } scrollState_t;

    function automatic logic [2:0] resetChar(input int unsigned idx);
        case (idx)
            0:       return CH_D;
            1:       return CH_E;
            2:       return CH_1;
            default: return CH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Maps a 3-bit character code onto its active-low seven-segment pattern.
module seg7_char_decode
    import hex_scroll_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            CH_D:     seg_o = SEG_D;
            CH_E:     seg_o = SEG_E;
            CH_1:     seg_o = SEG_1;
            CH_BLANK: seg_o = SEG_BLANK;
            CH_H:     seg_o = SEG_H;
            CH_L:     seg_o = SEG_L;
            CH_O:     seg_o = SEG_O;
            CH_P:     seg_o = SEG_P;
        endcase
    end

endmodule

// File: rtl/hex_scroll_display.sv
// Scrolls a switch-loaded word buffer across the HEX digits at a prescaled
// rate, with run/pause and direction taken from the synchronised switches.
module hex_scroll_display
    import hex_scroll_pkg::*;
#(
    parameter int unsigned NUM_HEX  = 6,
    parameter int unsigned WORD_LEN = 8,
    parameter int unsigned TICK_DIV = 50000000
)
(
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    input  logic [9:0]           SW,
    output logic [9:0]           LEDR,
    output logic [7*NUM_HEX-1:0] HEX
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       POS_MAX = 4'(WORD_LEN - 1);

    logic [9:0]           swMeta_q;
    logic [9:0]           swSync_q;
    logic                 loadPrev_q;
    scrollState_t         state_q, state_d;
    logic [CNT_W-1:0]     prescale_q, prescale_d;
    logic [3:0]           pos_q, pos_d;
    logic [3:0]           wptr_q, wptr_d;
    logic [2:0]           wordBuf_q [WORD_LEN];
    logic [9:0]           ledr_q, ledr_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;
    logic                 tick;
    logic                 loadPulse;
    logic                 unusedSwBits;

    assign unusedSwBits = ^swSync_q[6:3];

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            swMeta_q   <= '0;
            swSync_q   <= '0;
            loadPrev_q <= 1'b0;
        end else begin
            swMeta_q   <= SW;
            swSync_q   <= swMeta_q;
            loadPrev_q <= swSync_q[8];
        end
    end

    assign loadPulse = swSync_q[8] & ~loadPrev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSE: if (swSync_q[9])  state_d = RUN;
            RUN:   if (!swSync_q[9]) state_d = PAUSE;
        endcase
    end

    // The prescaler only counts while staying in RUN, so every entry into RUN
    // starts a full TICK_DIV period before the first step.
    always_comb begin
        tick       = (state_q == RUN) && (prescale_q == CNT_MAX);
        prescale_d = '0;
        if ((state_q == RUN) && (state_d == RUN) && !tick) begin
            prescale_d = prescale_q + CNT_W'(1);
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            if (swSync_q[7]) begin
                pos_d = (pos_q == 4'd0) ? POS_MAX : pos_q - 4'd1;
            end else begin
                pos_d = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
            end
        end
        wptr_d = wptr_q;
        if (loadPulse) begin
            wptr_d = (wptr_q == POS_MAX) ? 4'd0 : wptr_q + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q    <= PAUSE;
            prescale_q <= '0;
            pos_q      <= 4'd0;
            wptr_q     <= 4'd0;
            for (int unsigned i = 0; i < WORD_LEN; i++) begin
                wordBuf_q[i] <= resetChar(i);
            end
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            pos_q      <= pos_d;
            wptr_q     <= wptr_d;
            if (loadPulse) begin
                wordBuf_q[wptr_q[IDX_W-1:0]] <= swSync_q[2:0];
            end
        end
    end

    // During reset the decoders see the power-on word at pos 0, so the
    // registered HEX comes out of reset already showing it.
    for (genvar k = 0; k < NUM_HEX; k++) begin : g_digit
        localparam int unsigned OFFSET = NUM_HEX - 1 - k;
        logic [IDX_W-1:0] slotIdx;
        logic [2:0]       code;

        assign slotIdx = IDX_W'((32'(pos_q) + OFFSET) % WORD_LEN);
        assign code    = Reset ? resetChar(OFFSET) : wordBuf_q[slotIdx];

        seg7_char_decode u_decode (
            .code_i (code),
            .seg_o  (hex_d[7*k +: 7])
        );
    end

    assign ledr_d = {(state_q == RUN), 1'b0, swSync_q[7], 3'b000, pos_q};

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            ledr_q <= '0;
        end else begin
            ledr_q <= ledr_d;
        end
        hex_q <= hex_d;
    end

    assign LEDR = ledr_q;
    assign HEX  = hex_q;

endmodule

// File: tb/tb_hex_scroll_display.sv
// Scenario bench for hex_scroll_display with NUM_HEX=6, WORD_LEN=8, TICK_DIV=4,
// using a queue of expected HEX/LEDR snapshots per scenario.
module tb_hex_scroll_display;

    localparam int NUM_HEX  = 6;
    localparam int WORD_LEN = 8;
    localparam int TICK_DIV = 4;

    logic        CLOCK_50 = 1'b0;
    logic        Reset    = 1'b1;
    logic [9:0]  SW       = '0;
    logic [9:0]  LEDR;
    logic [41:0] HEX;

    always #10 CLOCK_50 = ~CLOCK_50;

    hex_scroll_display #(
        .NUM_HEX  (NUM_HEX),
        .WORD_LEN (WORD_LEN),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .SW       (SW),
        .LEDR     (LEDR),
        .HEX      (HEX)
    );

    typedef struct {
        string       tag;
        int          delay;
        logic [41:0] hex;
        logic [9:0]  ledr;
    } expT;

    expT        sbQ[$];
    int         assertCount = 0;
    int         failCount   = 0;
    logic [2:0] word [WORD_LEN];

    function automatic logic [6:0] segOf(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0100001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1111001;
            3'd3:    return 7'b1111111;
            3'd4:    return 7'b0001001;
            3'd5:    return 7'b1000111;
            3'd6:    return 7'b0100011;
            default: return 7'b0001100;
        endcase
    endfunction

    // Leftmost digit (k = NUM_HEX-1) shows word[pos].
    function automatic logic [41:0] hexFor(input int pos);
        logic [41:0] r;
        int          idx;
        r = '0;
        for (int k = 0; k < NUM_HEX; k++) begin
            idx = (pos + NUM_HEX - 1 - k) % WORD_LEN;
            r[7*k +: 7] = segOf(word[idx]);
        end
        return r;
    endfunction

    function automatic logic [9:0] ledrFor(input bit run, input bit dir, input int pos);
        logic [9:0] r;
        r      = '0;
        r[9]   = run;
        r[7]   = dir;
        r[3:0] = pos[3:0];
        return r;
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        SW    = '0;
        stepCycles(2);
        Reset = 1'b0;
        for (int i = 0; i < WORD_LEN; i++) begin
            word[i] = (i < 3) ? 3'(i) : 3'd3;
        end
    endtask

    task automatic test_reset();
        expT e;
        doReset();
        sbQ.push_back('{"reset", 0, hexFor(0), 10'd0});
        sbQ.push_back('{"reset idle", 3, hexFor(0), 10'd0});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
    endtask

    // RUN edge lands 3 cycles after the pin, first step 4 later, LEDR 1 later.
    task automatic test_scroll_left();
        expT e;
        doReset();
        SW[9] = 1'b1;
        sbQ.push_back('{"left pos1", 8, hexFor(1), ledrFor(1, 0, 1)});
        for (int p = 2; p <= WORD_LEN; p++) begin
            sbQ.push_back('{$sformatf("left pos%0d", p % WORD_LEN), 4,
                            hexFor(p % WORD_LEN), ledrFor(1, 0, p % WORD_LEN)});
        end
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
    endtask

    task automatic test_scroll_right();
        expT e;
        doReset();
        SW[9] = 1'b1;
        SW[7] = 1'b1;
        sbQ.push_back('{"right wrap pos7", 8, hexFor(7), ledrFor(1, 1, 7)});
        sbQ.push_back('{"right pos6", 4, hexFor(6), ledrFor(1, 1, 6)});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
        SW[7] = 1'b0;
        sbQ.push_back('{"dir change pos7", 4, hexFor(7), ledrFor(1, 0, 7)});
        e = sbQ.pop_front();
        stepCycles(e.delay);
        assertCount++;
        if (HEX !== e.hex) begin
            failCount++;
            $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
        end
        assertCount++;
        if (LEDR !== e.ledr) begin
            failCount++;
            $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
        end
    endtask

    task automatic test_pause();
        expT e;
        doReset();
        SW[9] = 1'b1;
        stepCycles(3);
        SW[9] = 1'b0;
        sbQ.push_back('{"pause running", 1, hexFor(0), ledrFor(1, 0, 0)});
        sbQ.push_back('{"pause entered", 3, hexFor(0), 10'd0});
        sbQ.push_back('{"pause frozen", 12, hexFor(0), 10'd0});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
        SW[9] = 1'b1;
        sbQ.push_back('{"resume before step", 7, hexFor(0), ledrFor(1, 0, 0)});
        sbQ.push_back('{"resume step", 1, hexFor(1), ledrFor(1, 0, 1)});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
    endtask

    task automatic test_load_pause();
        expT        e;
        logic [2:0] codes [5];
        codes = '{3'd4, 3'd1, 3'd5, 3'd5, 3'd6};
        doReset();
        for (int i = 0; i < 5; i++) begin
            SW[2:0] = codes[i];
            SW[8]   = 1'b1;
            stepCycles(2);
            SW[8]   = 1'b0;
            word[i] = codes[i];
            sbQ.push_back('{$sformatf("load %0d", i), 2, hexFor(0), 10'd0});
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
        SW[2:0] = 3'd7;
        SW[8]   = 1'b1;
        stepCycles(10);
        SW[8]   = 1'b0;
        word[5] = 3'd7;
        sbQ.push_back('{"load held once", 4, hexFor(0), 10'd0});
        e = sbQ.pop_front();
        stepCycles(e.delay);
        assertCount++;
        if (HEX !== e.hex) begin
            failCount++;
            $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
        end
        SW[9] = 1'b1;
        sbQ.push_back('{"loaded word pos1", 8, hexFor(1), ledrFor(1, 0, 1)});
        sbQ.push_back('{"loaded word pos2", 4, hexFor(2), ledrFor(1, 0, 2)});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
    endtask

    // Load strobe raised so its write edge coincides with the first tick.
    task automatic test_simultaneous();
        expT e;
        doReset();
        SW[9] = 1'b1;
        SW[7] = 1'b1;
        stepCycles(4);
        SW[2:0] = 3'd4;
        SW[8]   = 1'b1;
        sbQ.push_back('{"simul before", 3, hexFor(0), ledrFor(1, 1, 0)});
        word[0] = 3'd4;
        sbQ.push_back('{"simul after", 1, hexFor(7), ledrFor(1, 1, 7)});
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            stepCycles(e.delay);
            assertCount++;
            if (HEX !== e.hex) begin
                failCount++;
                $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
            end
            assertCount++;
            if (LEDR !== e.ledr) begin
                failCount++;
                $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
            end
        end
        SW[8] = 1'b0;
        stepCycles(5);
        Reset = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            word[i] = (i < 3) ? 3'(i) : 3'd3;
        end
        sbQ.push_back('{"midrun reset", 1, hexFor(0), 10'd0});
        e = sbQ.pop_front();
        stepCycles(e.delay);
        assertCount++;
        if (HEX !== e.hex) begin
            failCount++;
            $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
        end
        assertCount++;
        if (LEDR !== e.ledr) begin
            failCount++;
            $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
        end
        stepCycles(1);
        Reset = 1'b0;
        sbQ.push_back('{"after reset run", 8, hexFor(7), ledrFor(1, 1, 7)});
        e = sbQ.pop_front();
        stepCycles(e.delay);
        assertCount++;
        if (HEX !== e.hex) begin
            failCount++;
            $display("[TB] FAIL %s HEX got %h expected %h", e.tag, HEX, e.hex);
        end
        assertCount++;
        if (LEDR !== e.ledr) begin
            failCount++;
            $display("[TB] FAIL %s LEDR got %h expected %h", e.tag, LEDR, e.ledr);
        end
    endtask

    initial begin
        test_reset();
        test_scroll_left();
        test_scroll_right();
        test_pause();
        test_load_pause();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
